uart_tx: RTL and testbench

Serial UART transmitter that sits downstream of the push-button debouncer. It accepts a one-cycle `send` strobe, typically the debouncer's clean press pulse, together with a byte. It serialises the byte onto `tx` as 8N1 (or 8E1), LSB first. A one-entry holding buffer absorbs a press that arrives mid-frame; a further press while the buffer is full is dropped and flagged.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle.
// restart holds the counter at zero so the next state entry starts a full bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = (cnt_q == CNT_TERM);

    // Wrapping at terminal doubles as the reset-on-entry for the following state.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer and overrun flag.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       buf_full_q, buf_full_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buf_q, buf_d;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic bit_done;
    logic stop_exit;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == ST_IDLE),
        .bit_done(bit_done)
    );

    assign stop_exit = (state_q == ST_STOP) && bit_done;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        overrun_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d   = ^buf_q;
`endif
                        state_d    = ST_START;
                    end else if (send) begin
                        shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^tx_data;
`endif
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mid-frame request: at stop exit a full buffer has just been freed, an empty one was bypassed.
        if (send && (state_q != ST_IDLE)) begin
            if (stop_exit) begin
                if (buf_full_q) begin
                    buf_d      = tx_data;
                    buf_full_d = 1'b1;
                end
            end else if (!buf_full_q) begin
                buf_d      = tx_data;
                buf_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Line level follows the current state, registered one cycle later.
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = UART_IDLE_LVL;
        endcase
        busy_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Payload registers carry no reset; they are only observed after a load.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        buf_q    <= buf_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (CLKS_PER_BIT = 4) with a byte scoreboard and frame monitor.
// Honours UART_TX_PARITY_EN for frame length and parity checks.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FR = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, busy, overrun;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .tx_data(tx_data),
        .tx     (tx),
        .busy   (busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    int          mon_pos = -1;
    logic [7:0]  mon_exp = 8'h00;
    logic [FR-1:0] mon_obs = '0;
    logic [FR-1:0] last_obs = '0;
    int frames = 0;
    int busy_run = 0;
    int last_run = 0;
    int ovr_count = 0;
    int f0, o0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FR-1:0] frame_ref(input logic [7:0] b);
        logic [FR-1:0] r;
        int bi;
        r = '0;
        for (int k = 0; k < FR; k++) begin
            bi = k / CPB;
            if (bi == 0)              r[k] = 1'b0;
            else if (bi <= 8)         r[k] = b[bi-1];
            else if (bi == NBITS - 1) r[k] = 1'b1;
            else                      r[k] = ^b;
        end
        return r;
    endfunction

    // Frame monitor: captures every cycle of a frame and checks it against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mon_pos  = -1;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
            if (overrun) ovr_count++;
            if (mon_pos < 0 && tx == 1'b0) begin
                mon_pos = 0;
                chk("frame_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) mon_exp = sb.pop_front();
                else mon_exp = 8'h00;
            end
            if (mon_pos >= 0) begin
                mon_obs[mon_pos] = tx;
                if (mon_pos == FR - 1) begin
                    chk("frame", 64'(mon_obs), 64'(frame_ref(mon_exp)));
                    last_obs = mon_obs;
                    frames++;
                    mon_pos = -1;
                end else begin
                    mon_pos++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit expect_tx);
        @(posedge clk);
        #1;
        send = 1'b1;
        tx_data = b;
        if (expect_tx) sb.push_back(b);
        @(posedge clk);
        #1;
        send = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && mon_pos < 0) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_tx", 64'(tx), 64'd1);

        // Single byte and one-cycle output latency
        send_byte(8'h55, 1'b1);
        chk("lat_busy_n", 64'(busy), 64'd0);
        chk("lat_tx_n", 64'(tx), 64'd1);
        @(posedge clk);
        #1;
        chk("lat_busy_n1", 64'(busy), 64'd1);
        chk("lat_tx_n1", 64'(tx), 64'd0);
        wait_idle("single");
        chk("single_busy_len", 64'(last_run), 64'(FR));
        chk("single_frames", 64'(frames), 64'd1);

        // Back-to-back through the holding buffer
        f0 = frames; o0 = ovr_count;
        send_byte(8'h41, 1'b1);
        repeat (8) @(posedge clk);
        send_byte(8'h42, 1'b1);
        wait_idle("b2b");
        chk("b2b_busy_len", 64'(last_run), 64'(2 * FR));
        chk("b2b_frames", 64'(frames - f0), 64'd2);
        chk("b2b_no_overrun", 64'(ovr_count - o0), 64'd0);

        // Overrun: third byte dropped
        f0 = frames; o0 = ovr_count;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        chk("ovr_pulse", 64'(overrun), 64'd1);
        @(posedge clk);
        #1;
        chk("ovr_one_cycle", 64'(overrun), 64'd0);
        wait_idle("ovr");
        chk("ovr_count", 64'(ovr_count - o0), 64'd1);
        chk("ovr_frames", 64'(frames - f0), 64'd2);
        chk("ovr_busy_len", 64'(last_run), 64'(2 * FR));

        // send in the stop-exit cycle with the buffer full
        f0 = frames; o0 = ovr_count;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (FR - 4) @(posedge clk);
        send_byte(8'h7E, 1'b1);
        chk("simul_full_no_ovr", 64'(overrun), 64'd0);
        wait_idle("simul_full");
        chk("simul_full_frames", 64'(frames - f0), 64'd3);
        chk("simul_full_busy_len", 64'(last_run), 64'(3 * FR));
        chk("simul_full_ovr_count", 64'(ovr_count - o0), 64'd0);

        // send in the stop-exit cycle with the buffer empty
        f0 = frames;
        send_byte(8'h33, 1'b1);
        repeat (FR - 2) @(posedge clk);
        send_byte(8'h44, 1'b1);
        wait_idle("simul_empty");
        chk("simul_empty_frames", 64'(frames - f0), 64'd2);
        chk("simul_empty_busy_len", 64'(last_run), 64'(2 * FR));

        // Reset during data bit 3 with a byte waiting in the buffer
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (16) @(posedge clk);
        #2;
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
        repeat (FR + 10) @(posedge clk);
        #1;
        chk("midrst_buf_empty", 64'(busy), 64'd0);
        f0 = frames;
        send_byte(8'hA5, 1'b1);
        wait_idle("midrst_after");
        chk("midrst_after_len", 64'(last_run), 64'(FR));
        chk("midrst_after_frames", 64'(frames - f0), 64'd1);

        // Parity bit and frame length
        send_byte(8'h07, 1'b1);
        wait_idle("par07");
        chk("par07_len", 64'(last_run), 64'(FR));
`ifdef UART_TX_PARITY_EN
        chk("par07_bit", 64'(last_obs[9*CPB+1]), 64'd1);
        chk("par07_len44", 64'(last_run), 64'd44);
`else
        chk("nopar_len40", 64'(last_run), 64'd40);
`endif
        send_byte(8'h03, 1'b1);
        wait_idle("par03");
`ifdef UART_TX_PARITY_EN
        chk("par03_bit", 64'(last_obs[9*CPB+1]), 64'd0);
`else
        chk("par03_stop", 64'(last_obs[9*CPB+1]), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
